dm_cache_core: RTL

- Direct-mapped, write-through, no-write-allocate, one-word-per-line cache.
- Sits directly downstream of the AXI4-Lite-to-core translator. It consumes that translator's core_req_* stream and produces its core_resp_* pulse.
- Misses and all writes go to backing memory through an AXI4-Lite master port.
- Handles one outstanding request at a time.

---
 rtl/dm_cache_core.sv | 318 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/dm_cache_core.sv
// dm_cache_core: direct-mapped, write-through, no-write-allocate cache with
// one 32-bit word per line and one outstanding request at a time.
//
// Ports:
//   clk, rst               rising-edge clock, asynchronous active-high reset
//   core_req_*             request stream (valid/ready, we, addr, wdata, wstrb)
//   core_resp_*            one-cycle completion pulse (is_write, rdata, resp)
//   inv_all                invalidate-all pulse; deferred while busy
//   m_aw*/m_w*/m_b*        AXI4-Lite write channels (master side)
//   m_ar*/m_r*             AXI4-Lite read channels (master side)
//   hit_cnt, miss_cnt      wrapping read hit / read miss counters
//   dbg_state              current FSM state encoding
module dm_cache_core #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LINES  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    core_req_valid,
  output logic                    core_req_ready,
  input  logic                    core_req_we,
  input  logic [ADDR_WIDTH-1:0]   core_req_addr,
  input  logic [DATA_WIDTH-1:0]   core_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] core_req_wstrb,
  output logic                    core_resp_valid,
  output logic                    core_resp_is_write,
  output logic [DATA_WIDTH-1:0]   core_resp_rdata,
  output logic [1:0]              core_resp_resp,
  input  logic                    inv_all,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt,
  output logic [2:0]              dbg_state
);

  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_WIDTH - IDX_W - 2;
  localparam int WADR_W = ADDR_WIDTH - 2;
  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_RD_AR  = 3'd2,
    S_RD_R   = 3'd3,
    S_WR_AW  = 3'd4,
    S_WR_B   = 3'd5,
    S_RESP   = 3'd6
  } state_e;

  // Byte-lane merge of new data into an existing word under a strobe mask.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
      else         res[8*b +: 8] = old_w[8*b +: 8];
    end
    return res;
  endfunction

  state_e                state_q, state_d;
  logic [NUM_LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q  [NUM_LINES];
  logic [TAG_W-1:0]      tag_d  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_q [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_d [NUM_LINES];

  // Latched request; only the word address is kept since bits [1:0] are ignored.
  logic                  req_we_q, req_we_d;
  logic [WADR_W-1:0]     req_waddr_q, req_waddr_d;
  logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
  logic [STRB_W-1:0]     req_wstrb_q, req_wstrb_d;
  logic                  req_hit_q, req_hit_d;

  logic                  inv_pend_q, inv_pend_d;
  logic [31:0]           hit_cnt_q, hit_cnt_d;
  logic [31:0]           miss_cnt_q, miss_cnt_d;

  logic arvalid_q, arvalid_d, rready_q, rready_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;

  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_is_write_q, resp_is_write_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic [1:0]            resp_resp_q, resp_resp_d;

  logic [IDX_W-1:0] idx_s;
  logic [TAG_W-1:0] tag_s;
  logic             hit_s;
  logic             aw_done_s, w_done_s;
  logic             unused_addr_lsb_s;

  assign idx_s     = req_waddr_q[IDX_W-1:0];
  assign tag_s     = req_waddr_q[WADR_W-1:IDX_W];
  assign hit_s     = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
  // A channel counts as done if it already handshook or handshakes this cycle.
  assign aw_done_s = !awvalid_q || m_awready;
  assign w_done_s  = !wvalid_q || m_wready;
  assign unused_addr_lsb_s = ^core_req_addr[1:0];

  assign core_req_ready     = (state_q == S_IDLE) && !inv_pend_q && !inv_all;
  assign core_resp_valid    = resp_valid_q;
  assign core_resp_is_write = resp_is_write_q;
  assign core_resp_rdata    = resp_rdata_q;
  assign core_resp_resp     = resp_resp_q;
  assign m_awaddr  = {req_waddr_q, 2'b00};
  assign m_araddr  = {req_waddr_q, 2'b00};
  assign m_wdata   = req_wdata_q;
  assign m_wstrb   = req_wstrb_q;
  assign m_awvalid = awvalid_q;
  assign m_wvalid  = wvalid_q;
  assign m_bready  = bready_q;
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;
  assign dbg_state = state_q;

  // Next-state, array update and registered-output computation.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    req_we_d    = req_we_q;
    req_waddr_d = req_waddr_q;
    req_wdata_d = req_wdata_q;
    req_wstrb_d = req_wstrb_q;
    req_hit_d   = req_hit_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    resp_valid_d    = 1'b0;
    resp_is_write_d = 1'b0;
    resp_rdata_d    = {DATA_WIDTH{1'b0}};
    resp_resp_d     = 2'b00;

    // An invalidate arriving while busy is remembered until the next IDLE cycle.
    if (inv_all && (state_q != S_IDLE)) inv_pend_d = 1'b1;
    else                                inv_pend_d = inv_pend_q;

    case (state_q)
      S_IDLE: begin
        if (inv_all || inv_pend_q) begin
          valid_d    = {NUM_LINES{1'b0}};
          inv_pend_d = 1'b0;
        end else if (core_req_valid) begin
          req_we_d    = core_req_we;
          req_waddr_d = core_req_addr[ADDR_WIDTH-1:2];
          req_wdata_d = core_req_wdata;
          req_wstrb_d = core_req_wstrb;
          state_d     = S_LOOKUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOOKUP: begin
        if (req_we_q) begin
          req_hit_d = hit_s;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = S_WR_AW;
        end else if (hit_s) begin
          hit_cnt_d    = hit_cnt_q + 32'd1;
          resp_valid_d = 1'b1;
          resp_rdata_d = data_q[idx_s];
          state_d      = S_RESP;
        end else begin
          miss_cnt_d = miss_cnt_q + 32'd1;
          arvalid_d  = 1'b1;
          state_d    = S_RD_AR;
        end
      end
      S_RD_AR: begin
        if (m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_R;
        end else begin
          arvalid_d = 1'b1;
        end
      end
      S_RD_R: begin
        if (m_rvalid) begin
          rready_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = m_rdata;
          resp_resp_d  = m_rresp;
          state_d      = S_RESP;
          // Only an OKAY read may fill the line; errors leave it untouched.
          if (m_rresp == 2'b00) begin
            valid_d[idx_s] = 1'b1;
            tag_d[idx_s]   = tag_s;
            data_d[idx_s]  = m_rdata;
          end else begin
            valid_d[idx_s] = valid_q[idx_s];
          end
        end else begin
          rready_d = 1'b1;
        end
      end
      S_WR_AW: begin
        if (m_awready) awvalid_d = 1'b0;
        else           awvalid_d = awvalid_q;
        if (m_wready)  wvalid_d  = 1'b0;
        else           wvalid_d  = wvalid_q;
        if (aw_done_s && w_done_s) begin
          bready_d = 1'b1;
          state_d  = S_WR_B;
        end else begin
          state_d = S_WR_AW;
        end
      end
      S_WR_B: begin
        if (m_bvalid) begin
          bready_d        = 1'b0;
          resp_valid_d    = 1'b1;
          resp_is_write_d = 1'b1;
          resp_resp_d     = m_bresp;
          state_d         = S_RESP;
          // Write-through: the cached copy is updated only if it was present
          // and memory accepted the write.
          if (req_hit_q && (m_bresp == 2'b00)) begin
            data_d[idx_s] = merge_bytes(data_q[idx_s], req_wdata_q, req_wstrb_q);
          end else begin
            data_d[idx_s] = data_q[idx_s];
          end
        end else begin
          bready_d = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control, counter, handshake and response registers with async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      valid_q         <= {NUM_LINES{1'b0}};
      req_we_q        <= 1'b0;
      req_waddr_q     <= {WADR_W{1'b0}};
      req_wdata_q     <= {DATA_WIDTH{1'b0}};
      req_wstrb_q     <= {STRB_W{1'b0}};
      req_hit_q       <= 1'b0;
      inv_pend_q      <= 1'b0;
      hit_cnt_q       <= 32'd0;
      miss_cnt_q      <= 32'd0;
      arvalid_q       <= 1'b0;
      rready_q        <= 1'b0;
      awvalid_q       <= 1'b0;
      wvalid_q        <= 1'b0;
      bready_q        <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_is_write_q <= 1'b0;
      resp_rdata_q    <= {DATA_WIDTH{1'b0}};
      resp_resp_q     <= 2'b00;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      req_we_q        <= req_we_d;
      req_waddr_q     <= req_waddr_d;
      req_wdata_q     <= req_wdata_d;
      req_wstrb_q     <= req_wstrb_d;
      req_hit_q       <= req_hit_d;
      inv_pend_q      <= inv_pend_d;
      hit_cnt_q       <= hit_cnt_d;
      miss_cnt_q      <= miss_cnt_d;
      arvalid_q       <= arvalid_d;
      rready_q        <= rready_d;
      awvalid_q       <= awvalid_d;
      wvalid_q        <= wvalid_d;
      bready_q        <= bready_d;
      resp_valid_q    <= resp_valid_d;
      resp_is_write_q <= resp_is_write_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_resp_q     <= resp_resp_d;
    end
  end

  // Tag and data storage; no reset needed because valid bits gate every use.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule
